// File: rtl/lrn_window_buffer.sv
`timescale 1ns/1ps
// lrn_window_buffer
// Captures one pixel's channel vector from GLB read data, then walks every
// channel c, accumulating the sum of squares over channels
// [c-HALF_WIN, c+HALF_WIN] (clipped to the vector), and hands
// (x[c], 1 + sum) to the shared divider. Each returned quotient is
// registered onto wr_data for the mapper's GLB write.
module lrn_window_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int M_WIDTH    = 10,
  parameter int CH_AW      = 5,
  parameter int HALF_WIN   = 1,
  parameter int ACC_WIDTH  = 35
) (
  input  logic                  core_clk,
  input  logic                  reset,
  input  logic                  start_normalization,
  input  logic [M_WIDTH-1:0]    dim3,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  full_flag,
  output logic                  div_in_valid,
  output logic [DATA_WIDTH-1:0] div_numer,
  output logic [ACC_WIDTH-1:0]  div_denom,
  input  logic                  div_out_valid,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  normalized_window,
  output logic                  overflow_err
);

  localparam int DEPTH = 1 << CH_AW;
  localparam int CNT_W = CH_AW + 1;  // holds 1..DEPTH
  localparam int IDX_W = CH_AW + 2;  // headroom for c + HALF_WIN

  typedef enum logic [2:0] {
    S_FILL     = 3'd0,
    S_SUM      = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_DIV = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Channel vector storage. Small enough to live in fabric registers; SUM
  // needs a fresh operand every cycle, so it is read combinationally.
  logic [DATA_WIDTH-1:0] buf_q [DEPTH];

  logic [CNT_W-1:0]      dim3_eff_q, dim3_eff_d, dim3_last;
  logic                  dim3_too_big;
  logic [CH_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CH_AW-1:0]      c_q, c_d;
  logic [CH_AW-1:0]      j_q, j_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  full_q, full_d;
  logic                  nw_q, nw_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] numer_q, numer_d;
  logic [ACC_WIDTH-1:0]  denom_q, denom_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  // Strobes decoded from the current state
  logic                  accept_rd;
  logic                  awaiting_div;
  logic                  fill_wr;
  logic                  fill_last;
  logic                  rd_drop;
  logic                  div_accept;
  logic                  div_stray;
  logic                  sum_step;
  logic                  sum_last;
  logic                  last_ch;
  logic [CH_AW-1:0]      wr_addr;

  // Window arithmetic
  logic [IDX_W-1:0]        c_ext, lim, hi_c;
  logic [DATA_WIDTH-1:0]   opnd;
  logic [2*DATA_WIDTH-1:0] sq;
  logic [ACC_WIDTH-1:0]    acc_sum;

  // Lowest channel of the window centred on ch, clipped at channel 0.
  function automatic logic [CH_AW-1:0] lo_of(input logic [CH_AW-1:0] ch);
    if (ch >= CH_AW'(HALF_WIN)) begin
      return ch - CH_AW'(HALF_WIN);
    end
    return '0;
  endfunction

  // Effective channel count: zero means one channel, oversize is clamped.
  always_comb begin
    dim3_too_big = (dim3 > M_WIDTH'(DEPTH));
    if (dim3 == '0) begin
      dim3_eff_d = CNT_W'(1);
    end else if (dim3_too_big) begin
      dim3_eff_d = CNT_W'(DEPTH);
    end else begin
      dim3_eff_d = dim3[CNT_W-1:0];
    end
  end

  // Layer configuration: changes only on start_normalization, survives reset
  // so a refill after an abort uses the layer's channel count.
  always_ff @(posedge core_clk) begin
    if (start_normalization) begin
      dim3_eff_q <= dim3_eff_d;
    end
  end

  assign dim3_last = dim3_eff_q - CNT_W'(1);

  // Upper window edge for the current channel, clipped at the last channel.
  assign c_ext = IDX_W'(c_q);
  assign lim   = IDX_W'(dim3_last);
  assign hi_c  = ((c_ext + IDX_W'(HALF_WIN)) >= lim) ? lim : (c_ext + IDX_W'(HALF_WIN));

  // Squared operand, zero-extended into the accumulator width.
  assign opnd    = buf_q[j_q];
  assign sq      = {{DATA_WIDTH{1'b0}}, opnd} * {{DATA_WIDTH{1'b0}}, opnd};
  assign acc_sum = acc_q + ACC_WIDTH'(sq);

  // Output/strobe decode from the current state
  always_comb begin
    div_in_valid = (state_q == S_ISSUE);
    accept_rd    = (state_q == S_FILL) || (state_q == S_DONE);
    awaiting_div = (state_q == S_ISSUE) || (state_q == S_WAIT_DIV);
    // A new window arriving in DONE always restarts at channel 0.
    wr_addr      = (state_q == S_DONE) ? '0 : wr_ptr_q;
    fill_wr      = rd_valid && accept_rd && !start_normalization;
    fill_last    = fill_wr && ({1'b0, wr_addr} == dim3_last);
    rd_drop      = rd_valid && !accept_rd;
    div_accept   = div_out_valid && awaiting_div && !start_normalization;
    div_stray    = div_out_valid && !awaiting_div;
    sum_step     = (state_q == S_SUM) && !start_normalization;
    sum_last     = (IDX_W'(j_q) == hi_c);
    last_ch      = ({1'b0, c_q} == dim3_last);
  end

  // FSM state register
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (start_normalization) begin
      state_d = S_FILL;
    end else begin
      case (state_q)
        S_FILL, S_DONE: begin
          if (fill_wr) begin
            state_d = fill_last ? S_SUM : S_FILL;
          end
        end
        S_SUM: begin
          if (sum_last) begin
            state_d = S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT_DIV: begin
          if (div_out_valid) begin
            state_d = last_ch ? S_DONE : S_SUM;
          end else begin
            state_d = S_WAIT_DIV;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  // Channel buffer write port
  always_ff @(posedge core_clk) begin
    if (fill_wr) begin
      buf_q[wr_addr] <= rd_data;
    end
  end

  // Datapath next-state: pointers, accumulator, divider operands, flags
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    c_d       = c_q;
    j_d       = j_q;
    acc_d     = acc_q;
    full_d    = full_q;
    nw_d      = nw_q;
    ovf_d     = ovf_q;
    numer_d   = numer_q;
    denom_d   = denom_q;
    wr_data_d = wr_data_q;
    if (start_normalization) begin
      wr_ptr_d = '0;
      c_d      = '0;
      j_d      = '0;
      acc_d    = '0;
      full_d   = 1'b0;
      nw_d     = 1'b0;
      ovf_d    = dim3_too_big;
    end else begin
      if (rd_drop || div_stray) begin
        ovf_d = 1'b1;
      end
      if (fill_wr) begin
        wr_ptr_d = wr_addr + 1'b1;
        nw_d     = 1'b0;
        if (fill_last) begin
          full_d = 1'b1;
          c_d    = '0;
          j_d    = '0;  // window of channel 0 starts at channel 0
        end
      end
      if (sum_step) begin
        acc_d = acc_sum;
        if (sum_last) begin
          // Operands latched here stay put until the quotient returns.
          numer_d = buf_q[c_q];
          denom_d = acc_sum + ACC_WIDTH'(1);
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      if (div_accept) begin
        wr_data_d = div_quotient;
        acc_d     = '0;
        if (last_ch) begin
          nw_d   = 1'b1;
          full_d = 1'b0;
        end else begin
          c_d = c_q + 1'b1;
          j_d = lo_of(c_q + 1'b1);
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      c_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      full_q    <= 1'b0;
      nw_q      <= 1'b0;
      ovf_q     <= 1'b0;
      numer_q   <= '0;
      denom_q   <= '0;
      wr_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      c_q       <= c_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      full_q    <= full_d;
      nw_q      <= nw_d;
      ovf_q     <= ovf_d;
      numer_q   <= numer_d;
      denom_q   <= denom_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign full_flag         = full_q;
  assign normalized_window = nw_q;
  assign overflow_err      = ovf_q;
  assign div_numer         = numer_q;
  assign div_denom         = denom_q;
  assign wr_data           = wr_data_q;

endmodule

// File: tb/tb_lrn_window_buffer.sv
`timescale 1ns/1ps
// Bench for lrn_window_buffer: a behavioural LRN model predicts every divider
// request; a divider responder with programmable latency returns quotients.
module tb_lrn_window_buffer;

  localparam int DW   = 16;
  localparam int MW   = 10;
  localparam int AW   = 5;
  localparam int HW   = 1;
  localparam int ACCW = 35;

  logic            core_clk = 1'b0;
  logic            reset;
  logic            start_normalization;
  logic [MW-1:0]   dim3;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            full_flag;
  logic            div_in_valid;
  logic [DW-1:0]   div_numer;
  logic [ACCW-1:0] div_denom;
  logic            div_out_valid;
  logic [DW-1:0]   div_quotient;
  logic [DW-1:0]   wr_data;
  logic            normalized_window;
  logic            overflow_err;

  lrn_window_buffer #(
    .DATA_WIDTH(DW), .M_WIDTH(MW), .CH_AW(AW), .HALF_WIN(HW), .ACC_WIDTH(ACCW)
  ) dut (
    .core_clk(core_clk),
    .reset(reset),
    .start_normalization(start_normalization),
    .dim3(dim3),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .full_flag(full_flag),
    .div_in_valid(div_in_valid),
    .div_numer(div_numer),
    .div_denom(div_denom),
    .div_out_valid(div_out_valid),
    .div_quotient(div_quotient),
    .wr_data(wr_data),
    .normalized_window(normalized_window),
    .overflow_err(overflow_err)
  );

  always #5 core_clk = ~core_clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [DW-1:0]   words [0:39];
  logic [DW-1:0]   exp_numer [$];
  logic [ACCW-1:0] exp_denom [$];
  logic [ACCW-1:0] log_denom [$];
  logic [DW-1:0]   log_numer [$];

  int   lat       = 0;
  int   q_cnt     = 0;
  logic stray_req = 1'b0;

  logic            outstanding = 1'b0;
  logic [DW-1:0]   exp_wr      = '0;
  logic [DW-1:0]   held_n      = '0;
  logic [ACCW-1:0] held_d      = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // LRN reference: for each channel, sum of squares over the clipped window.
  function automatic void build_model(input int n);
    exp_numer.delete();
    exp_denom.delete();
    for (int c = 0; c < n; c++) begin
      longint unsigned s;
      s = 0;
      for (int k = c - HW; k <= c + HW; k++) begin
        if (k >= 0 && k < n) s += longint'(words[k]) * longint'(words[k]);
      end
      exp_numer.push_back(words[c]);
      exp_denom.push_back(ACCW'(s + 1));
    end
  endfunction

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  // Divider stand-in: answers each request `lat` cycles after div_in_valid.
  initial begin
    div_out_valid = 1'b0;
    div_quotient  = '0;
    forever begin
      @(posedge core_clk);
      #1;
      div_out_valid = 1'b0;
      if (stray_req) begin
        div_quotient  = 16'hDEAD;
        div_out_valid = 1'b1;
        stray_req     = 1'b0;
      end else if (div_in_valid && !reset) begin
        for (int k = 0; k < lat; k++) begin
          @(posedge core_clk);
          #1;
        end
        div_quotient  = 16'h1000 + 16'(q_cnt * 259);
        q_cnt++;
        div_out_valid = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge core_clk) begin
    if (reset) begin
      exp_wr      = '0;
      outstanding = 1'b0;
    end else begin
      check("wr_data", {48'h0, wr_data}, {48'h0, exp_wr});
      if (outstanding && !div_in_valid) begin
        check("numer_held", {48'h0, div_numer}, {48'h0, held_n});
        check("denom_held", {29'h0, div_denom}, {29'h0, held_d});
      end
      if (div_in_valid) begin
        check("no_overlap", {63'h0, outstanding}, 64'h0);
        check("req_expected", {63'h0, exp_numer.size() > 0}, 64'h1);
        if (exp_numer.size() > 0) begin
          logic [DW-1:0]   en;
          logic [ACCW-1:0] ed;
          en = exp_numer.pop_front();
          ed = exp_denom.pop_front();
          check("req_numer", {48'h0, div_numer}, {48'h0, en});
          check("req_denom", {29'h0, div_denom}, {29'h0, ed});
        end
        $display("req numer=%0h denom=%0h", div_numer, div_denom);
        log_numer.push_back(div_numer);
        log_denom.push_back(div_denom);
        outstanding = 1'b1;
        held_n      = div_numer;
        held_d      = div_denom;
      end
      if (div_out_valid && outstanding) begin
        exp_wr      = div_quotient;
        outstanding = 1'b0;
        $display("rsp quotient=%0h", div_quotient);
      end
      if (normalized_window) check("nw_idle", {63'h0, outstanding}, 64'h0);
    end
  end

  task automatic start(input int d);
    start_normalization = 1'b1;
    dim3 = MW'(d);
    tick();
    start_normalization = 1'b0;
    check("start_full", {63'h0, full_flag}, 64'h0);
    check("start_nw", {63'h0, normalized_window}, 64'h0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      rd_valid = 1'b1;
      rd_data  = words[i];
      tick();
      if (i == 0) check("nw_clear", {63'h0, normalized_window}, 64'h0);
      if (i < n - 1) check("full_early", {63'h0, full_flag}, 64'h0);
    end
    rd_valid = 1'b0;
    check("full_set", {63'h0, full_flag}, 64'h1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!normalized_window && k < 3000) begin
      tick();
      k++;
    end
    check({name, "_done"}, {63'h0, normalized_window}, 64'h1);
    check({name, "_all_reqs"}, 64'(exp_numer.size()), 64'h0);
    check({name, "_full_low"}, {63'h0, full_flag}, 64'h0);
  endtask

  task automatic stray_rd(input logic [DW-1:0] v);
    rd_valid = 1'b1;
    rd_data  = v;
    tick();
    rd_valid = 1'b0;
    check("stray_rd_ovf", {63'h0, overflow_err}, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start_normalization = 1'b0;
    dim3 = '0;
    rd_data = '0;
    rd_valid = 1'b0;
    repeat (3) tick();
    check("rst_full", {63'h0, full_flag}, 64'h0);
    check("rst_div_in", {63'h0, div_in_valid}, 64'h0);
    check("rst_numer", {48'h0, div_numer}, 64'h0);
    check("rst_denom", {29'h0, div_denom}, 64'h0);
    check("rst_wr", {48'h0, wr_data}, 64'h0);
    check("rst_nw", {63'h0, normalized_window}, 64'h0);
    check("rst_ovf", {63'h0, overflow_err}, 64'h0);
    reset = 1'b0;
    tick();

    // dim3=4, data 1..4, zero-latency divider
    lat = 0;
    start(4);
    check("ovf_clear4", {63'h0, overflow_err}, 64'h0);
    for (int i = 0; i < 4; i++) words[i] = 16'(i + 1);
    build_model(4);
    log_numer.delete();
    log_denom.delete();
    fill(4);
    wait_done("dim4_lat0");
    check("lit_n0", {48'h0, log_numer[0]}, 64'd1);
    check("lit_d0", {29'h0, log_denom[0]}, 64'd6);
    check("lit_d1", {29'h0, log_denom[1]}, 64'd15);
    check("lit_d2", {29'h0, log_denom[2]}, 64'd30);
    check("lit_n3", {48'h0, log_numer[3]}, 64'd4);
    check("lit_d3", {29'h0, log_denom[3]}, 64'd26);
    check("lit_wr_last", {48'h0, wr_data}, 64'h1000 + 64'(3 * 259));

    // Latency 1, with a dropped rd_valid while summing
    lat = 1;
    start(4);
    build_model(4);
    fill(4);
    stray_rd(16'h5555);
    wait_done("dim4_lat1");

    // Latency 17
    lat = 17;
    start(4);
    check("ovf_cleared", {63'h0, overflow_err}, 64'h0);
    build_model(4);
    fill(4);
    wait_done("dim4_lat17");

    // Back-to-back window straight out of DONE
    lat = 3;
    words[0] = 16'd9; words[1] = 16'd0; words[2] = 16'hFFFF; words[3] = 16'd3;
    build_model(4);
    fill(4);
    wait_done("b2b");

    // dim3=1, full-scale word: one-cycle window
    lat = 2;
    start(1);
    words[0] = 16'hFFFF;
    build_model(1);
    log_denom.delete();
    fill(1);
    check("d1_sum_cycle", {63'h0, div_in_valid}, 64'h0);
    tick();
    check("d1_issue", {63'h0, div_in_valid}, 64'h1);
    wait_done("dim1");
    check("lit_d1_denom", {29'h0, log_denom[0]}, 64'hFFFE0002);

    // dim3=0 treated as one channel
    start(0);
    check("ovf_dim0", {63'h0, overflow_err}, 64'h0);
    words[0] = 16'd5;
    build_model(1);
    log_denom.delete();
    fill(1);
    wait_done("dim0");
    check("lit_d0_denom", {29'h0, log_denom[0]}, 64'd26);

    // dim3=40 clamped to 32; a 33rd word during SUM is dropped
    lat = 1;
    start(40);
    check("ovf_clamp", {63'h0, overflow_err}, 64'h1);
    for (int i = 0; i < 32; i++) words[i] = 16'(i * 977 + 13);
    build_model(32);
    fill(32);
    stray_rd(16'h7777);
    wait_done("dim40");
    check("ovf_sticky", {63'h0, overflow_err}, 64'h1);

    // Stray quotient in FILL: error flag, wr_data untouched (checked per cycle)
    start(4);
    check("ovf_pre_stray", {63'h0, overflow_err}, 64'h0);
    stray_req = 1'b1;
    repeat (3) tick();
    check("stray_div_ovf", {63'h0, overflow_err}, 64'h1);

    // Reset in the middle of SUM, then a plain refill
    for (int i = 0; i < 4; i++) words[i] = 16'(i + 1);
    build_model(4);
    fill(4);
    tick();
    reset = 1'b1;
    #1;
    exp_numer.delete();
    exp_denom.delete();
    check("mid_rst_full", {63'h0, full_flag}, 64'h0);
    check("mid_rst_ovf", {63'h0, overflow_err}, 64'h0);
    check("mid_rst_numer", {48'h0, div_numer}, 64'h0);
    check("mid_rst_denom", {29'h0, div_denom}, 64'h0);
    check("mid_rst_wr", {48'h0, wr_data}, 64'h0);
    tick();
    check("mid_rst_div_in", {63'h0, div_in_valid}, 64'h0);
    reset = 1'b0;
    tick();
    words[0] = 16'd7; words[1] = 16'd1; words[2] = 16'd2; words[3] = 16'd8;
    build_model(4);
    fill(4);
    wait_done("post_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
